// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Interrupt support is compiled in with the PC_SEQ_IRQ_EN macro.
package pc_seq_pkg;

  localparam int unsigned ADDR_W = 16;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_VECTOR = 16'h0000;
  localparam logic [ADDR_W-1:0] DEFAULT_IRQ_VECTOR   = 16'h0004;

  typedef enum logic [1:0] {
    ST_RESET_VEC = 2'd0,
    ST_FETCH     = 2'd1,
    ST_HALTED    = 2'd2
  } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Counter, fetch-handshake and control signals between the sequencer and its neighbours.
// The irq/irq_ack/epc signals are always present; they only do work with PC_SEQ_IRQ_EN.
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic [ADDR_W-1:0] pc;
  logic              load;
  logic [ADDR_W-1:0] load_data;
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic              halt;
  logic              resume;
  logic              halted;
  logic              irq;
  logic              irq_ack;
  logic [ADDR_W-1:0] epc;

  modport master (
    input  pc, fetch_ready, branch_valid, branch_target, halt, resume, irq,
    output load, load_data, fetch_valid, fetch_addr, halted, irq_ack, epc
  );

  modport slave (
    output pc, fetch_ready, branch_valid, branch_target, halt, resume, irq,
    input  load, load_data, fetch_valid, fetch_addr, halted, irq_ack, epc
  );

endinterface

// File: rtl/pc_sequencer_redirect_buf.sv
// Single-entry buffer for a redirect that arrives while a fetch is stalled.
// A new capture overwrites the old target; capture wins over clear.
module redirect_buf
  import pc_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              clear,
  input  logic [ADDR_W-1:0] target,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_target
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (capture) begin
      pend_valid  <= 1'b1;
      pend_target <= target;
    end else if (clear) begin
      pend_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: drives the counter's load port and the fetch handshake.
// Optional interrupt entry is enabled by defining PC_SEQ_IRQ_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR   = DEFAULT_IRQ_VECTOR
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  state_t            state;
  logic              halt_req;
  logic              accept;
  logic              halt_any;
  logic              irq_take;
  logic              redir;
  logic [ADDR_W-1:0] redir_tgt;
  logic              buf_capture;
  logic              buf_clear;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_target;

  assign accept    = (state == ST_FETCH) && bus.fetch_ready;
  assign halt_any  = bus.halt || halt_req;
  assign redir     = bus.branch_valid || pend_valid;
  assign redir_tgt = bus.branch_valid ? bus.branch_target : pend_target;
  assign bus.fetch_addr = bus.pc;

  redirect_buf u_redirect_buf (
    .clk         (clk),
    .rst         (rst),
    .capture     (buf_capture),
    .clear       (buf_clear),
    .target      (bus.branch_target),
    .pend_valid  (pend_valid),
    .pend_target (pend_target)
  );

`ifdef PC_SEQ_IRQ_EN
  logic [ADDR_W-1:0] seq_next;
  logic              irq_ack_q;
  logic [ADDR_W-1:0] epc_q;

  // Halt outranks the interrupt; the interrupt only enters on an accepted fetch.
  assign irq_take = accept && bus.irq && !halt_any;
  assign seq_next = redir ? redir_tgt : bus.pc + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_ack_q <= 1'b0;
      epc_q     <= '0;
    end else begin
      irq_ack_q <= irq_take;
      if (irq_take) epc_q <= seq_next;
    end
  end

  assign bus.irq_ack = irq_ack_q;
  assign bus.epc     = epc_q;
`else
  logic [ADDR_W:0] unused_irq;

  assign unused_irq  = {bus.irq, IRQ_VECTOR};
  assign irq_take    = 1'b0;
  assign bus.irq_ack = 1'b0;
  assign bus.epc     = '0;
`endif

  // Counter control: hold by default, increment only on a plain accepted fetch.
  always_comb begin
    bus.load      = 1'b1;
    bus.load_data = bus.pc;
    buf_capture   = 1'b0;
    buf_clear     = 1'b0;
    if (rst) begin
      bus.load_data = RESET_VECTOR;
    end else begin
      case (state)
        ST_RESET_VEC: bus.load_data = RESET_VECTOR;
        ST_FETCH: begin
          if (accept) begin
            buf_clear = 1'b1;
            if (irq_take)   bus.load_data = IRQ_VECTOR;
            else if (redir) bus.load_data = redir_tgt;
            else            bus.load      = 1'b0;
          end else begin
            buf_capture = bus.branch_valid;
          end
        end
        ST_HALTED: if (bus.branch_valid) bus.load_data = bus.branch_target;
        default: bus.load_data = RESET_VECTOR;
      endcase
    end
  end

  // State, handshake and halt flags; a halt seen during a stall waits for acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_RESET_VEC;
      halt_req        <= 1'b0;
      bus.fetch_valid <= 1'b0;
      bus.halted      <= 1'b0;
    end else begin
      case (state)
        ST_RESET_VEC: begin
          state           <= ST_FETCH;
          bus.fetch_valid <= 1'b1;
        end
        ST_FETCH: begin
          if (accept) begin
            halt_req <= 1'b0;
            if (halt_any) begin
              state           <= ST_HALTED;
              bus.fetch_valid <= 1'b0;
              bus.halted      <= 1'b1;
            end
          end else if (bus.halt) begin
            halt_req <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (bus.resume && !bus.halt) begin
            state           <= ST_FETCH;
            bus.fetch_valid <= 1'b1;
            bus.halted      <= 1'b0;
          end
        end
        default: begin
          state           <= ST_RESET_VEC;
          bus.fetch_valid <= 1'b0;
          bus.halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: models the program counter and the sequencing rules,
// runs directed scenarios then random traffic. Define PC_SEQ_IRQ_EN to cover interrupts.
module tb_pc_sequencer;

  localparam logic [15:0] RV = 16'h0100;
  localparam logic [15:0] IV = 16'h0004;

  localparam int M_UNK    = 0;
  localparam int M_ENTRY  = 1;
  localparam int M_FETCH  = 2;
  localparam int M_HALTED = 3;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] cnt = 16'h0000;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_VECTOR(RV), .IRQ_VECTOR(IV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // The counter the sequencer controls.
  always @(posedge clk) cnt <= bus.load ? bus.load_data : cnt + 16'd1;
  assign bus.pc = cnt;

  int n_checks = 0;
  int n_errors = 0;

  int          m_mode = M_UNK;
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_pend_t = 16'h0000;
  logic [15:0] m_epc = 16'h0000;
  bit          m_pend_v = 1'b0;
  bit          m_haltreq = 1'b0;
  bit          m_ack = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare against the model, then advance past the edge.
  task automatic step(input bit r, input bit rdy, input bit bv, input logic [15:0] bt,
                      input bit hl, input bit rs, input bit iq);
    logic [15:0] nxt;
    bit inc, take_irq;
    rst = r; bus.fetch_ready = rdy; bus.branch_valid = bv; bus.branch_target = bt;
    bus.halt = hl; bus.resume = rs; bus.irq = iq;
    #1;
    nxt = m_pc; inc = 1'b0; take_irq = 1'b0;
    if (r) nxt = RV;
    else if (m_mode == M_ENTRY) nxt = RV;
    else if (m_mode == M_FETCH && rdy) begin
      if (bv) nxt = bt;
      else if (m_pend_v) nxt = m_pend_t;
      else begin nxt = m_pc + 16'd1; inc = 1'b1; end
`ifdef PC_SEQ_IRQ_EN
      take_irq = iq && !hl && !m_haltreq;
`endif
    end else if (m_mode == M_HALTED && bv) nxt = bt;

    chk("load", 16'(bus.load), 16'(!(inc && !take_irq)));
    if (!(inc && !take_irq)) chk("load_data", bus.load_data, take_irq ? IV : nxt);
    if (m_mode != M_UNK) begin
      chk("fetch_valid", 16'(bus.fetch_valid), 16'(m_mode == M_FETCH));
      if (m_mode == M_FETCH) chk("fetch_addr", bus.fetch_addr, m_pc);
      chk("halted", 16'(bus.halted), 16'(m_mode == M_HALTED));
      chk("pc", bus.pc, m_pc);
      chk("irq_ack", 16'(bus.irq_ack), 16'(m_ack));
      chk("epc", bus.epc, m_epc);
    end

    m_ack = 1'b0;
    if (r) begin
      m_mode = M_ENTRY; m_pc = RV; m_pend_v = 1'b0; m_epc = 16'h0000; m_haltreq = 1'b0;
    end else if (m_mode == M_ENTRY) begin
      m_mode = M_FETCH; m_pc = nxt;
    end else if (m_mode == M_FETCH) begin
      if (rdy) begin
        if (hl || m_haltreq) m_mode = M_HALTED;
        if (take_irq) begin m_epc = nxt; m_pc = IV; m_ack = 1'b1; end
        else m_pc = nxt;
        m_pend_v = 1'b0; m_haltreq = 1'b0;
      end else begin
        if (bv) begin m_pend_v = 1'b1; m_pend_t = bt; end
        if (hl) m_haltreq = 1'b1;
      end
    end else if (m_mode == M_HALTED) begin
      m_pc = nxt;
      if (rs && !hl) m_mode = M_FETCH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go(input bit rdy);
    step(1'b0, rdy, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic br(input bit rdy, input logic [15:0] t);
    step(1'b0, rdy, 1'b1, t, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] rt;
    // Reset release and sequential fetches.
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("rst_fetch_valid", 16'(bus.fetch_valid), 16'h0000);
    chk("rst_halted", 16'(bus.halted), 16'h0000);
    go(1'b1);
    chk("first_addr", bus.fetch_addr, 16'h0100);
    go(1'b1);
    chk("second_addr", bus.fetch_addr, 16'h0101);
    go(1'b1);
    chk("third_addr", bus.fetch_addr, 16'h0102);

    // Stall at 0200.
    br(1'b1, 16'h0200);
    go(1'b0); go(1'b0); go(1'b0);
    chk("stall_addr", bus.fetch_addr, 16'h0200);
    go(1'b1);
    chk("after_stall", bus.fetch_addr, 16'h0201);

    // Two redirects during a stall: last wins.
    br(1'b0, 16'h0300);
    br(1'b0, 16'h0400);
    go(1'b1);
    chk("last_wins", bus.fetch_addr, 16'h0400);

    // Wrap-around.
    br(1'b1, 16'hFFFF);
    chk("at_ffff", bus.fetch_addr, 16'hFFFF);
    go(1'b1);
    chk("wrap", bus.fetch_addr, 16'h0000);

    // Halt during a stalled fetch.
    br(1'b1, 16'h0500);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    go(1'b1);
    chk("halt_entered", 16'(bus.halted), 16'h0001);
    for (int i = 0; i < 5; i++) go(1'b1);
    chk("halt_hold_pc", bus.pc, 16'h0501);
    step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    chk("halt_beats_resume", 16'(bus.halted), 16'h0001);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("resume_valid", 16'(bus.fetch_valid), 16'h0001);
    chk("resume_addr", bus.fetch_addr, 16'h0501);

`ifdef PC_SEQ_IRQ_EN
    // Interrupt entry at an accepted fetch of 0600.
    br(1'b1, 16'h0600);
    step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("irq_ack_pulse", 16'(bus.irq_ack), 16'h0001);
    chk("irq_epc", bus.epc, 16'h0601);
    chk("irq_vector", bus.fetch_addr, IV);
    go(1'b1);
    chk("irq_ack_drop", 16'(bus.irq_ack), 16'h0000);
`endif

    // Reset in the middle of a stalled fetch.
    br(1'b0, 16'h0700);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_pc", bus.pc, RV);
    chk("mid_rst_epc", bus.epc, 16'h0000);
    go(1'b1);
    go(1'b1);
    chk("mid_rst_refetch", bus.pc, 16'h0101);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rt = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, rt,
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
